// File: rtl/lfsr_seq_ctrl.sv
// Sequencing controller around a WIDTH-bit Galois LFSR: seed load, counted word streaming over valid/ready.
// Optional period measurement is built when LFSR_PERIOD_CHECK_EN is defined.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for seed_load / start; LFSR holds its value
// RUN     | out_valid high; LFSR steps and words_left drops per accepted word
// DONE    | single-cycle completion pulse (done=1, busy=1), then IDLE
module lfsr_seq_ctrl #(
   parameter int unsigned      WIDTH     = 5,
   parameter logic [WIDTH-1:0] TAPS      = 5'b00100,
   parameter int unsigned      CNT_W     = 8,
   parameter logic [WIDTH-1:0] RST_STATE = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] words_left,
   output logic             seed_fixed,
   output logic [WIDTH:0]   period_len,
   output logic             period_ok
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] lfsr_q;
   logic [WIDTH-1:0] lfsr_next;
   logic [WIDTH-1:0] seed_eff;
   logic             seed_is_zero;
   logic             step_en;
   logic             load_en;

   always_comb begin
      lfsr_next    = '0;
      lfsr_next[0] = lfsr_q[WIDTH-1];
      for (int i = 1; i < int'(WIDTH); i++) begin
         lfsr_next[i] = lfsr_q[i-1] ^ (TAPS[i] & lfsr_q[WIDTH-1]);
      end
   end

   // A zero seed would lock the LFSR; substitute 1 and flag it.
   assign seed_is_zero = (seed == '0);
   assign seed_eff     = seed_is_zero ? WIDTH'(1) : seed;

   // abort wins over a same-cycle handshake, so it suppresses the step.
   assign step_en  = (state == ST_RUN) && !abort && out_ready;
   assign load_en  = (state == ST_IDLE) && seed_load;
   assign out_data = lfsr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         lfsr_q     <= RST_STATE;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         words_left <= '0;
         seed_fixed <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (load_en) begin
                  lfsr_q     <= seed_eff;
                  seed_fixed <= seed_is_zero;
               end
               if (start) begin
                  words_left <= count;
                  busy       <= 1'b1;
                  if (count == '0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state     <= ST_RUN;
                     out_valid <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state      <= ST_IDLE;
                  out_valid  <= 1'b0;
                  busy       <= 1'b0;
                  words_left <= '0;
               end else if (step_en) begin
                  lfsr_q     <= lfsr_next;
                  words_left <= words_left - CNT_W'(1);
                  if (words_left == CNT_W'(1)) begin
                     state     <= ST_DONE;
                     out_valid <= 1'b0;
                     done      <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state     <= ST_IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

`ifdef LFSR_PERIOD_CHECK_EN
   localparam logic [WIDTH:0] FULL_PERIOD = {1'b0, {WIDTH{1'b1}}};

   logic [WIDTH-1:0] origin;
   logic [WIDTH:0]   period_cnt;
   logic [WIDTH:0]   cnt_inc;

   assign cnt_inc = period_cnt + {{WIDTH{1'b0}}, 1'b1};

   // Counts steps since the last reset/seed load; a return to origin closes a measurement.
   always_ff @(posedge clk) begin
      if (rst) begin
         origin     <= RST_STATE;
         period_cnt <= '0;
         period_len <= '0;
         period_ok  <= 1'b0;
      end else if (load_en) begin
         origin     <= seed_eff;
         period_cnt <= '0;
         period_len <= '0;
         period_ok  <= 1'b0;
      end else if (step_en) begin
         if (lfsr_next == origin) begin
            period_len <= cnt_inc;
            period_ok  <= (cnt_inc == FULL_PERIOD);
            period_cnt <= '0;
         end else begin
            period_cnt <= cnt_inc;
         end
      end
   end
`else
   assign period_len = '0;
   assign period_ok  = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl with hand-computed LFSR sequences (WIDTH=5, TAPS=00100).
module tb_lfsr_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       seed_load;
   logic [4:0] seed;
   logic       start;
   logic [7:0] count;
   logic       abort;
   logic       out_valid;
   logic       out_ready;
   logic [4:0] out_data;
   logic       busy;
   logic       done;
   logic [7:0] words_left;
   logic       seed_fixed;
   logic [5:0] period_len;
   logic       period_ok;

   int n_checks = 0;
   int n_fail   = 0;

   lfsr_seq_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .seed_load  (seed_load),
      .seed       (seed),
      .start      (start),
      .count      (count),
      .abort      (abort),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy),
      .done       (done),
      .words_left (words_left),
      .seed_fixed (seed_fixed),
      .period_len (period_len),
      .period_ok  (period_ok)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   logic [4:0] exp_seq [4];
   logic       rdy_pat [5];
   int         accepted;

   initial begin
      rst = 1'b1; seed_load = 1'b0; seed = '0; start = 1'b0;
      count = '0; abort = 1'b0; out_ready = 1'b0;

      // Reset state
      do_reset();
      check_eq("rst_valid",  32'(out_valid),  0);
      check_eq("rst_busy",   32'(busy),       0);
      check_eq("rst_done",   32'(done),       0);
      check_eq("rst_wleft",  32'(words_left), 0);
      check_eq("rst_data",   32'(out_data),   32'h1f);
      check_eq("rst_sfix",   32'(seed_fixed), 0);
      check_eq("rst_plen",   32'(period_len), 0);
      check_eq("rst_pok",    32'(period_ok),  0);

      // Run of 4 words from reset state, ready held high
      exp_seq[0] = 5'b11111; exp_seq[1] = 5'b11011;
      exp_seq[2] = 5'b10011; exp_seq[3] = 5'b00011;
      start = 1'b1; count = 8'd4; out_ready = 1'b1;
      tick();
      start = 1'b0;
      check_eq("r4_wleft0", 32'(words_left), 4);
      for (int k = 0; k < 4; k++) begin
         check_eq("r4_valid", 32'(out_valid), 1);
         check_eq("r4_data",  32'(out_data),  32'(exp_seq[k]));
         check_eq("r4_busy",  32'(busy),      1);
         check_eq("r4_done0", 32'(done),      0);
         tick();
      end
      check_eq("r4_done",   32'(done),       1);
      check_eq("r4_dbusy",  32'(busy),       1);
      check_eq("r4_dvalid", 32'(out_valid),  0);
      check_eq("r4_final",  32'(out_data),   32'h06);
      check_eq("r4_wleft",  32'(words_left), 0);
      tick();
      check_eq("r4_idle_done", 32'(done), 0);
      check_eq("r4_idle_busy", 32'(busy), 0);

      // Zero seed plus start in the same cycle
      seed_load = 1'b1; seed = 5'b00000; start = 1'b1; count = 8'd2;
      tick();
      seed_load = 1'b0; start = 1'b0;
      check_eq("z_sfix",   32'(seed_fixed), 1);
      check_eq("z_data0",  32'(out_data),   32'h01);
      check_eq("z_valid",  32'(out_valid),  1);
      tick();
      check_eq("z_data1",  32'(out_data),   32'h02);
      tick();
      check_eq("z_done",   32'(done),       1);
      check_eq("z_final",  32'(out_data),   32'h04);
      tick();

      // count=3 with stalls; LFSR starts at 00100
      rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0;
      rdy_pat[3] = 1'b1; rdy_pat[4] = 1'b1;
      start = 1'b1; count = 8'd3;
      tick();
      start = 1'b0;
      check_eq("st_wleft3", 32'(words_left), 3);
      check_eq("st_data0",  32'(out_data),   32'h04);
      accepted = 0;
      for (int k = 0; k < 5; k++) begin
         out_ready = rdy_pat[k];
         #1;
         if (out_valid && out_ready) accepted++;
         tick();
         case (k)
            0: begin check_eq("st_d1", 32'(out_data), 32'h08); check_eq("st_w1", 32'(words_left), 2); end
            1: begin check_eq("st_d2", 32'(out_data), 32'h08); check_eq("st_w2", 32'(words_left), 2); end
            2: begin check_eq("st_d3", 32'(out_data), 32'h08); check_eq("st_w3", 32'(words_left), 2); end
            3: begin check_eq("st_d4", 32'(out_data), 32'h10); check_eq("st_w4", 32'(words_left), 1); end
            default: begin
               check_eq("st_d5",   32'(out_data),   32'h05);
               check_eq("st_w5",   32'(words_left), 0);
               check_eq("st_done", 32'(done),       1);
            end
         endcase
      end
      check_eq("st_accepted", 32'(accepted), 3);
      out_ready = 1'b1;
      tick();

      // Abort after 2 accepted words
      do_reset();
      start = 1'b1; count = 8'd10; out_ready = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check_eq("ab_pre", 32'(out_data), 32'h13);
      abort = 1'b1;
      tick();
      check_eq("ab_valid", 32'(out_valid),  0);
      check_eq("ab_busy",  32'(busy),       0);
      check_eq("ab_done",  32'(done),       0);
      check_eq("ab_data",  32'(out_data),   32'h13);
      check_eq("ab_wleft", 32'(words_left), 0);
      // abort is ignored in IDLE, so this start still launches a run
      start = 1'b1; count = 8'd1;
      tick();
      start = 1'b0; abort = 1'b0;
      check_eq("ab_done2",   32'(done),      0);
      check_eq("ab_resvld",  32'(out_valid), 1);
      check_eq("ab_resdata", 32'(out_data),  32'h13);
      tick();
      check_eq("ab_resdone", 32'(done),      1);
      check_eq("ab_resfin",  32'(out_data),  32'h03);
      tick();

      // count=0 with a nonzero seed load
      seed_load = 1'b1; seed = 5'b01010; start = 1'b1; count = 8'd0;
      tick();
      seed_load = 1'b0; start = 1'b0;
      check_eq("c0_done",  32'(done),       1);
      check_eq("c0_busy",  32'(busy),       1);
      check_eq("c0_valid", 32'(out_valid),  0);
      check_eq("c0_sfix",  32'(seed_fixed), 0);
      check_eq("c0_data",  32'(out_data),   32'h0a);
      tick();
      check_eq("c0_idle",  32'(done),       0);
      check_eq("c0_ibusy", 32'(busy),       0);

      // Full period from reset
      do_reset();
      start = 1'b1; count = 8'd31; out_ready = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 31; k++) tick();
      check_eq("per_done", 32'(done),     1);
      check_eq("per_data", 32'(out_data), 32'h1f);
`ifdef LFSR_PERIOD_CHECK_EN
      check_eq("per_len",  32'(period_len), 31);
      check_eq("per_ok",   32'(period_ok),  1);
`else
      check_eq("per_len",  32'(period_len), 0);
      check_eq("per_ok",   32'(period_ok),  0);
`endif
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
